// File: rtl/rd_req_arbiter_pkg.sv
// Shared types and constants for the read-request arbiter: FSM states,
// requester indices, request type codes and the cache-line beat count.
`ifndef LINE_WORD_NUM
`define LINE_WORD_NUM 4
`endif

package rd_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam int NUM_REQ = 3;
  localparam int REQ_IC  = 0;
  localparam int REQ_DC  = 1;
  localparam int REQ_UC  = 2;

  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  // Normally supplied by definitions.svh; the fallback keeps the package standalone.
  localparam int LINE_WORD_NUM = `LINE_WORD_NUM;

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rd_req_arbiter_if.sv
// Requester-side and downstream-side bus of the read-request arbiter.
// slave = the arbiter's view, master = the surrounding environment.
interface rd_req_arbiter_if;
  logic [2:0]  req_valid;
  logic [8:0]  req_type;
  logic [95:0] req_addr;
  logic [2:0]  req_rdy;
  logic [2:0]  ret_valid;
  logic [2:0]  ret_last;
  logic [31:0] ret_data;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        dn_ret_valid;
  logic        dn_ret_last;
  logic [31:0] dn_ret_data;

  modport slave (
    input  req_valid, req_type, req_addr, rd_rdy, dn_ret_valid, dn_ret_last, dn_ret_data,
    output req_rdy, ret_valid, ret_last, ret_data, rd_req, rd_type, rd_addr
  );

  modport master (
    output req_valid, req_type, req_addr, rd_rdy, dn_ret_valid, dn_ret_last, dn_ret_data,
    input  req_rdy, ret_valid, ret_last, ret_data, rd_req, rd_type, rd_addr
  );
endinterface

// File: rtl/rd_req_arbiter_prio_sel.sv
// Combinational one-hot picker: dcache > uncached > icache, except that a
// starving icache request wins outright.
module rd_prio_sel
  import rd_req_arbiter_pkg::*;
(
  input  logic [2:0] req_valid,
  input  logic       starve_hit,
  output logic [2:0] grant
);

  always_comb begin
    grant = 3'b000;
    if (starve_hit && req_valid[REQ_IC]) begin
      grant[REQ_IC] = 1'b1;
    end else if (req_valid[REQ_DC]) begin
      grant[REQ_DC] = 1'b1;
    end else if (req_valid[REQ_UC]) begin
      grant[REQ_UC] = 1'b1;
    end else if (req_valid[REQ_IC]) begin
      grant[REQ_IC] = 1'b1;
    end else begin
      grant = 3'b000;
    end
  end

endmodule

// File: rtl/rd_req_arbiter.sv
// Three-way read-request arbiter with icache starvation protection; keeps a
// single transaction outstanding and routes its return beats back.
module rd_req_arbiter
  import rd_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_WORDS   = LINE_WORD_NUM
) (
  input  logic              clk,
  input  logic              resetn,
  rd_req_arbiter_if.slave   bus,
  output logic              busy,
  output logic              err
);

  localparam int SC_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int BEAT_W = 8;

  arb_state_e          state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          type_q, type_d;
  logic [31:0]         addr_q, addr_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                err_q, err_d;

  logic [2:0]          pick;
  logic [1:0]          pick_idx;
  logic                starve_hit;
  logic [BEAT_W-1:0]   exp_beats;
  logic [BEAT_W-1:0]   beat_inc;
  logic [2:0]          req_rdy_c, ret_valid_c, ret_last_c;

  assign starve_hit = (starve_q == SC_W'(STARVE_LIMIT));
  assign pick_idx   = onehot_to_idx(pick);
  assign exp_beats  = (type_q == RD_TYPE_LINE) ? BEAT_W'(LINE_WORDS) : 8'd1;
  assign beat_inc   = beat_q + 8'd1;

  rd_prio_sel u_prio_sel (
    .req_valid  (bus.req_valid),
    .starve_hit (starve_hit),
    .grant      (pick)
  );

  // Next-state, latch and error computation for the arbitration FSM.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    type_d   = type_q;
    addr_d   = addr_q;
    starve_d = starve_q;
    beat_d   = beat_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          state_d = ST_ISSUE;
          grant_d = pick;
          case (pick_idx)
            2'd1: begin
              type_d = bus.req_type[5:3];
              addr_d = bus.req_addr[63:32];
            end
            2'd2: begin
              type_d = bus.req_type[8:6];
              addr_d = bus.req_addr[95:64];
            end
            default: begin
              type_d = bus.req_type[2:0];
              addr_d = bus.req_addr[31:0];
            end
          endcase
          // Only a lost grant with icache waiting ages the starvation count.
          if (pick[REQ_IC] || !bus.req_valid[REQ_IC]) begin
            starve_d = '0;
          end else if (!starve_hit) begin
            starve_d = starve_q + SC_W'(1);
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
        if (bus.dn_ret_valid) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_ISSUE: begin
        if (bus.rd_rdy) begin
          state_d = ST_RESP;
          beat_d  = '0;
        end else begin
          state_d = ST_ISSUE;
        end
        if (bus.dn_ret_valid) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_RESP: begin
        if (bus.dn_ret_valid) begin
          beat_d = beat_inc;
          if (bus.dn_ret_last) begin
            state_d = ST_IDLE;
            if (beat_inc != exp_beats) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= 3'b000;
      type_q   <= 3'b000;
      addr_q   <= 32'h0000_0000;
      starve_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // Accept pulse and return routing go to the granted requester only.
  always_comb begin
    req_rdy_c   = 3'b000;
    ret_valid_c = 3'b000;
    ret_last_c  = 3'b000;
    if (state_q == ST_ISSUE && bus.rd_rdy) begin
      req_rdy_c = grant_q;
    end else begin
      req_rdy_c = 3'b000;
    end
    if (state_q == ST_RESP && bus.dn_ret_valid) begin
      ret_valid_c = grant_q;
      ret_last_c  = bus.dn_ret_last ? grant_q : 3'b000;
    end else begin
      ret_valid_c = 3'b000;
      ret_last_c  = 3'b000;
    end
  end

  assign bus.req_rdy   = req_rdy_c;
  assign bus.ret_valid = ret_valid_c;
  assign bus.ret_last  = ret_last_c;
  assign bus.ret_data  = bus.dn_ret_data;
  assign bus.rd_req    = (state_q == ST_ISSUE);
  assign bus.rd_type   = type_q;
  assign bus.rd_addr   = addr_q;
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Scoreboard bench for rd_req_arbiter: stimulus queues expected accepts and
// return beats, a negedge monitor pops and compares whenever the DUT shows one.
module tb_rd_req_arbiter;
  import rd_req_arbiter_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic busy, err;

  rd_req_arbiter_if bus();

  rd_req_arbiter #(.STARVE_LIMIT(4), .LINE_WORDS(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rdy;
    logic [2:0]  typ;
    logic [31:0] addr;
  } acc_t;

  typedef struct packed {
    logic [2:0]  vld;
    logic [2:0]  lst;
    logic [31:0] data;
  } ret_t;

  acc_t acc_q[$];
  ret_t ret_q[$];
  acc_t mon_a;
  ret_t mon_r;
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] a_tab [3];
  logic [2:0]  t_tab [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop an expectation whenever the DUT presents an accept or a return beat.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        if (bus.req_rdy !== 3'b000) begin
          if (acc_q.size() == 0) begin
            check("unexpected_req_rdy", 64'(bus.req_rdy), 64'd0);
          end else begin
            mon_a = acc_q.pop_front();
            check("req_rdy", 64'(bus.req_rdy), 64'(mon_a.rdy));
            check("rd_req", 64'(bus.rd_req), 64'd1);
            check("rd_addr", 64'(bus.rd_addr), 64'(mon_a.addr));
            check("rd_type", 64'(bus.rd_type), 64'(mon_a.typ));
          end
        end
        if (bus.ret_valid !== 3'b000 || bus.ret_last !== 3'b000) begin
          if (ret_q.size() == 0) begin
            check("unexpected_ret_valid", 64'(bus.ret_valid), 64'd0);
          end else begin
            mon_r = ret_q.pop_front();
            check("ret_valid", 64'(bus.ret_valid), 64'(mon_r.vld));
            check("ret_last", 64'(bus.ret_last), 64'(mon_r.lst));
            check("ret_data", 64'(bus.ret_data), 64'(mon_r.data));
          end
        end
      end
    end
  end

  // Queue the expected accept, wait (bounded) for it, check latency, step into RESP.
  task automatic issue(input logic [2:0] exp_g, input int exp_lat, input string nm);
    acc_t e;
    int lat;
    e.rdy  = exp_g;
    e.typ  = t_tab[onehot_to_idx(exp_g)];
    e.addr = a_tab[onehot_to_idx(exp_g)];
    acc_q.push_back(e);
    lat = 0;
    @(negedge clk);
    while (bus.req_rdy === 3'b000 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  // Drive n downstream beats starting at posedge+1, last flagged on beat last_at.
  task automatic beats(input int n, input logic [2:0] g, input int last_at, input logic [31:0] base);
    ret_t r;
    for (int i = 0; i < n; i++) begin
      bus.dn_ret_valid = 1'b1;
      bus.dn_ret_last  = (i == last_at);
      bus.dn_ret_data  = base + 32'(i);
      r.vld  = g;
      r.lst  = (i == last_at) ? g : 3'b000;
      r.data = base + 32'(i);
      ret_q.push_back(r);
      @(posedge clk);
      #1;
    end
    bus.dn_ret_valid = 1'b0;
    bus.dn_ret_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_tab[0] = 32'h1000_0000;
    a_tab[1] = 32'h2000_0004;
    a_tab[2] = 32'h3000_0008;
    t_tab[0] = 3'b100;
    t_tab[1] = 3'b010;
    t_tab[2] = 3'b010;
    resetn           = 1'b0;
    bus.req_valid    = 3'b000;
    bus.req_type     = {t_tab[2], t_tab[1], t_tab[0]};
    bus.req_addr     = {a_tab[2], a_tab[1], a_tab[0]};
    bus.rd_rdy       = 1'b1;
    bus.dn_ret_valid = 1'b0;
    bus.dn_ret_last  = 1'b0;
    bus.dn_ret_data  = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_req", 64'(bus.rd_req), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_req_rdy", 64'(bus.req_rdy), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // dcache beats icache on default priority.
    bus.req_valid = 3'b011;
    issue(3'b010, 1, "dc_over_ic");
    bus.req_valid = 3'b000;
    check("busy_in_resp", 64'(busy), 64'd1);
    beats(1, 3'b010, 0, 32'hA000_0000);
    check("t1_err", 64'(err), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);

    // icache line read, downstream stalls, requester drops valid during ISSUE.
    bus.rd_rdy    = 1'b0;
    bus.req_valid = 3'b001;
    @(posedge clk);
    #1;
    bus.req_valid = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_rd_req", 64'(bus.rd_req), 64'd1);
      check("stall_addr", 64'(bus.rd_addr), 64'(a_tab[0]));
    end
    @(posedge clk);
    #1;
    bus.rd_rdy = 1'b1;
    issue(3'b001, 0, "ic_after_stall");
    beats(4, 3'b001, 3, 32'hB000_0000);
    check("line_err", 64'(err), 64'd0);
    check("line_idle", 64'(busy), 64'd0);

    // icache starves: four dcache grants, icache wins the fifth.
    bus.req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      issue(3'b010, 1, "starve_dc");
      beats(1, 3'b010, 0, 32'hC000_0000 + 32'(k));
    end
    issue(3'b001, 1, "starve_ic");
    bus.req_valid = 3'b010;
    beats(4, 3'b001, 3, 32'hD000_0000);
    issue(3'b010, 1, "dc_after_ic");
    bus.req_valid = 3'b000;
    beats(1, 3'b010, 0, 32'hD100_0000);
    check("starve_err", 64'(err), 64'd0);

    // Uncached single-size read answered with two beats.
    bus.req_valid = 3'b100;
    issue(3'b100, 1, "uc");
    bus.req_valid = 3'b000;
    beats(2, 3'b100, 1, 32'hE000_0000);
    check("uc_len_err", 64'(err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 64'(err), 64'd1);

    // Reset during beat 2 of a response.
    bus.req_valid = 3'b010;
    issue(3'b010, 1, "dc_pre_reset");
    bus.req_valid = 3'b000;
    beats(1, 3'b010, 1, 32'hF000_0000);
    bus.dn_ret_valid = 1'b1;
    bus.dn_ret_data  = 32'hF000_0001;
    resetn = 1'b0;
    #1;
    check("rst_ret_valid", 64'(bus.ret_valid), 64'd0);
    check("rst_ret_last", 64'(bus.ret_last), 64'd0);
    check("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
    check("rst_rd_req", 64'(bus.rd_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    bus.dn_ret_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.req_valid = 3'b001;
    issue(3'b001, 1, "ic_post_reset");
    bus.req_valid = 3'b000;
    beats(4, 3'b001, 3, 32'h1234_0000);
    check("post_reset_err", 64'(err), 64'd0);

    // Stray downstream beat while idle.
    bus.dn_ret_valid = 1'b1;
    bus.dn_ret_last  = 1'b1;
    @(posedge clk);
    #1;
    bus.dn_ret_valid = 1'b0;
    bus.dn_ret_last  = 1'b0;
    check("stray_err", 64'(err), 64'd1);
    check("stray_busy", 64'(busy), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("acc_q_drained", 64'(acc_q.size()), 64'd0);
    check("ret_q_drained", 64'(ret_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
